// File: rtl/rcon_sequencer_if.sv
// rtl/rcon_sequencer_if.sv - handshake bundle for the key-schedule control sequencer
//
// Purpose: groups the request side (from the key controller) and the word
// descriptor stream (to the key-expansion datapath) into one bundle.
// Ports (signals):
//   start, mode       request from key controller
//   busy, done, err   status back to key controller
//   out_valid/ready   descriptor handshake
//   word_idx, rcon,
//   rot_sub, sub_only,
//   last              descriptor payload
// Modports: master = sequencer, slave = controller/consumer side.
interface rcon_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 6
);
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  word_idx;
  logic [WORD_W-1:0] rcon;
  logic              rot_sub;
  logic              sub_only;
  logic              last;
  logic              done;
  logic              err;

  modport master (
    input  start, mode, out_ready,
    output busy, out_valid, word_idx, rcon, rot_sub, sub_only, last, done, err
  );

  modport slave (
    output start, mode, out_ready,
    input  busy, out_valid, word_idx, rcon, rot_sub, sub_only, last, done, err
  );
endinterface

// File: rtl/rcon_sequencer.sv
// rtl/rcon_sequencer.sv - sequential AES key-schedule round-constant and transform-flag generator
//
// Purpose: on start, walks the expanded-key word index i from Nk to the final
// index for AES-128/192/256 and emits one registered descriptor per word
// (rcon, rot_sub, sub_only, last) over a valid/ready handshake.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rcon_sequencer_if.master (start/mode in, descriptor stream out,
//         busy/done/err status)
// Build option: RCON_LUT_EN selects a 10-entry constant table indexed by a
// round counter instead of the xtime register chain. Both builds behave
// identically at the ports.
module rcon_sequencer #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 6
) (
  input logic              clk,
  input logic              rst,
  rcon_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       mod_q, mod_d;
  logic             valid_q, valid_d;
  logic             rot_sub_q, rot_sub_d;
  logic             sub_only_q, sub_only_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       rc_cur;
  logic             handshake;

  // First word index of a schedule equals Nk.
  function automatic logic [IDX_W-1:0] first_idx(input logic [1:0] m);
    case (m)
      2'b00:   return IDX_W'(4);
      2'b01:   return IDX_W'(6);
      default: return IDX_W'(8);
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] final_idx(input logic [1:0] m);
    case (m)
      2'b00:   return IDX_W'(43);
      2'b01:   return IDX_W'(51);
      default: return IDX_W'(59);
    endcase
  endfunction

  // Nk-1, the wrap point of the mod counter (Nk=8 does not fit in 3 bits).
  function automatic logic [2:0] nk_m1(input logic [1:0] m);
    case (m)
      2'b00:   return 3'd3;
      2'b01:   return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

`ifdef RCON_LUT_EN
  logic [3:0] rnd_q, rnd_d;

  function automatic logic [7:0] rc_lut(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign rc_cur = rc_lut(rnd_q);
`else
  logic [7:0] rc_q, rc_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign rc_cur = rc_q;
`endif

  // valid_q is only ever set in RUN, so it qualifies the handshake alone.
  assign handshake = valid_q && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    mod_d      = mod_q;
    valid_d    = valid_q;
    rot_sub_d  = rot_sub_q;
    sub_only_d = sub_only_q;
    last_d     = last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef RCON_LUT_EN
    rnd_d      = rnd_q;
`else
    rc_d       = rc_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.mode == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d    = RUN;
            mode_d     = bus.mode;
            idx_d      = first_idx(bus.mode);
            mod_d      = 3'd0;
            valid_d    = 1'b1;
            rot_sub_d  = 1'b1;
            sub_only_d = 1'b0;
            last_d     = 1'b0;
`ifdef RCON_LUT_EN
            rnd_d      = 4'd1;
`else
            rc_d       = 8'h01;
`endif
          end
        end
      end

      RUN: begin
        if (handshake) begin
          if (last_q) begin
            state_d    = DONE;
            idx_d      = '0;
            mod_d      = 3'd0;
            valid_d    = 1'b0;
            rot_sub_d  = 1'b0;
            sub_only_d = 1'b0;
            last_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            mod_d = (mod_q == nk_m1(mode_q)) ? 3'd0 : mod_q + 3'd1;
            // rc advances after the word that consumed it.
            if (rot_sub_q) begin
`ifdef RCON_LUT_EN
              rnd_d = rnd_q + 4'd1;
`else
              rc_d  = xtime(rc_q);
`endif
            end
            // Flags are computed from the next index so they are registered.
            rot_sub_d  = (mod_d == 3'd0);
            sub_only_d = (nk_m1(mode_q) == 3'd7) && (mod_d == 3'd4);
            last_d     = (idx_d == final_idx(mode_q));
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      idx_q      <= '0;
      mod_q      <= 3'd0;
      valid_q    <= 1'b0;
      rot_sub_q  <= 1'b0;
      sub_only_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RCON_LUT_EN
      rnd_q      <= 4'd1;
`else
      rc_q       <= 8'h01;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      mod_q      <= mod_d;
      valid_q    <= valid_d;
      rot_sub_q  <= rot_sub_d;
      sub_only_q <= sub_only_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef RCON_LUT_EN
      rnd_q      <= rnd_d;
`else
      rc_q       <= rc_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = valid_q;
  assign bus.word_idx  = idx_q;
  assign bus.rcon      = rot_sub_q ? (WORD_W'(rc_cur) << (WORD_W - 8)) : '0;
  assign bus.rot_sub   = rot_sub_q;
  assign bus.sub_only  = sub_only_q;
  assign bus.last      = last_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
